// File: rtl/qc_ldpc_pkg.sv
// qc_ldpc_pkg: shared types and helpers for the QC-LDPC encode datapath.
package qc_ldpc_pkg;

    localparam int MAXZ_DEFAULT  = 81;
    localparam int ROW_W_DEFAULT = 4;
    localparam int ZMASK_W       = 256;

    typedef logic [ROW_W_DEFAULT-1:0] row_t;
    typedef logic [ZMASK_W-1:0]       zmask_t;

    typedef struct packed {
        logic valid;
        logic is_null;
        logic last;
        row_t row;
    } sideband_t;

    function automatic int shift_latency(input int maxz);
        return $clog2(maxz);
    endfunction

    // Bits [z-1:0] set and clipped to maxz; callers truncate to their own width.
    function automatic zmask_t zmask(input int z, input int maxz);
        zmask_t ones;
        ones = '1;
        return ~(ones << z) & ~(ones << maxz);
    endfunction

endpackage

// File: rtl/qc_acc_fifo.sv
// qc_acc_fifo: synchronous first-word fall-through FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module qc_acc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic                         rd_valid,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign rd_valid = (count != '0);
    assign do_pop   = pop && rd_valid;
    assign do_push  = push && ((count != CNT_W'(DEPTH)) || do_pop);

    // Empty FIFO presents zero so the output bus is clean after reset.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/qc_row_xor_accumulator.sv
// qc_row_xor_accumulator: aligns shifter output with its sideband, masks to Z and
// XOR-accumulates one parity block per base-matrix row. Optional macro: QC_ACC_ROWCHECK_EN.
module qc_row_xor_accumulator
    import qc_ldpc_pkg::*;
#(
    parameter int MAXZ          = MAXZ_DEFAULT,
    parameter int SHIFT_LATENCY = shift_latency(MAXZ),
    parameter int ROW_W         = $bits(row_t),
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_null,
    input  logic                    in_last,
    input  logic [ROW_W-1:0]        in_row,
    input  logic [$clog2(MAXZ):0]   z_val,
    input  logic [MAXZ-1:0]         shifted_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [MAXZ-1:0]         out_data,
    output logic [ROW_W-1:0]        out_row
`ifdef QC_ACC_ROWCHECK_EN
    ,
    output logic                    err_row
`endif
);

    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int LCNT_W = $clog2(SHIFT_LATENCY + 2);
    localparam int OCC_W  = ((FCNT_W > LCNT_W) ? FCNT_W : LCNT_W) + 1;

    sideband_t            sb [SHIFT_LATENCY];
    sideband_t            aligned;
    logic                 fire;
    logic [LCNT_W-1:0]    lasts_in_flight;
    logic [FCNT_W-1:0]    fifo_count;
    logic [OCC_W-1:0]     occupancy;
    logic [MAXZ-1:0]      zm;
    logic [MAXZ-1:0]      contrib;
    logic [MAXZ-1:0]      sum;
    logic [MAXZ-1:0]      acc;
    logic                 first;
    logic                 push;
    logic [MAXZ+ROW_W-1:0] fifo_rd;

    assign fire    = in_valid && in_ready;
    assign aligned = sb[SHIFT_LATENCY-1];

    // Rows already committed to the FIFO plus fired last beats still travelling
    // through the shifter; admitting only below depth means a push never finds it full.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(lasts_in_flight);
    assign in_ready  = occupancy < OCC_W'(FIFO_DEPTH);

    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int i = 0; i < SHIFT_LATENCY; i++) begin
                sb[i] <= '0;
            end
        end else begin
            sb[0] <= '{valid: fire, is_null: in_null, last: in_last, row: in_row};
            for (int i = 1; i < SHIFT_LATENCY; i++) begin
                sb[i] <= sb[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            lasts_in_flight <= '0;
        end else begin
            case ({fire && in_last, aligned.valid && aligned.last})
                2'b10:   lasts_in_flight <= lasts_in_flight + 1'b1;
                2'b01:   lasts_in_flight <= lasts_in_flight - 1'b1;
                default: lasts_in_flight <= lasts_in_flight;
            endcase
        end
    end

    assign zm      = MAXZ'(zmask(int'(z_val), MAXZ));
    assign contrib = aligned.is_null ? '0 : (shifted_data & zm);
    assign sum     = (first ? '0 : acc) ^ contrib;
    assign push    = aligned.valid && aligned.last;

    always_ff @(posedge CLK) begin
        if (rst) begin
            acc   <= '0;
            first <= 1'b1;
        end else if (aligned.valid) begin
            if (aligned.last) begin
                acc   <= '0;
                first <= 1'b1;
            end else begin
                acc   <= sum;
                first <= 1'b0;
            end
        end
    end

`ifdef QC_ACC_ROWCHECK_EN
    row_t cur_row;

    always_ff @(posedge CLK) begin
        if (rst) begin
            cur_row <= '0;
            err_row <= 1'b0;
        end else if (aligned.valid) begin
            if (first) begin
                cur_row <= aligned.row;
            end else if (aligned.row != cur_row) begin
                err_row <= 1'b1;
            end
        end
    end
`endif

    qc_acc_fifo #(
        .WIDTH (MAXZ + ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .rst       (rst),
        .push      (push),
        .push_data ({sum, aligned.row}),
        .pop       (out_ready),
        .rd_valid  (out_valid),
        .rd_data   (fifo_rd),
        .count     (fifo_count)
    );

    assign out_data = fifo_rd[ROW_W +: MAXZ];
    assign out_row  = fifo_rd[ROW_W-1:0];

endmodule
